// File: rtl/mha_bram_o_arbiter.sv
// Arbitrates the single O-matrix BRAM port among N_REQ MHA requesters (reads and write bursts), with a one-cycle gap between owners.
// Latency: grant and read ENA 1 cycle after request, each write beat 1 cycle after it is presented, read data 1 cycle after I_BRAM_RD_VLD.
// Backpressure: losers keep ENA asserted and wait with no timeout. Optional macro MHA_BRAM_ARB_FIXED_PRIO_EN gives lowest-index-wins priority instead of round-robin.
module mha_bram_o_arbiter #(
    parameter int N_REQ  = 4,
    parameter int D_W    = 16,
    parameter int SA_R   = 16,
    parameter int SA_C   = 16,
    parameter int LINE_W = 6,
    parameter int COL_W  = 3
) (
    input  logic                                              I_CLK,
    input  logic                                              I_RST_N,
    input  logic [N_REQ-1:0]                                  I_REQ_ENA,
    input  logic [N_REQ-1:0]                                  I_REQ_WEA,
    input  logic [N_REQ-1:0][LINE_W-1:0]                      I_REQ_LINE,
    input  logic [N_REQ-1:0][COL_W-1:0]                       I_REQ_COL,
    input  logic [N_REQ-1:0][SA_R-1:0][SA_C-1:0][D_W-1:0]     I_REQ_WR_MAT,
    output logic [N_REQ-1:0]                                  O_GNT,
    output logic [N_REQ-1:0]                                  O_REQ_RD_VLD,
    output logic [SA_R-1:0][SA_C-1:0][D_W-1:0]                O_REQ_RD_MAT,
    output logic                                              O_BRAM_ENA,
    output logic                                              O_BRAM_WEA,
    output logic [LINE_W-1:0]                                 O_BRAM_SEL_LINE,
    output logic [COL_W-1:0]                                  O_BRAM_SEL_COL,
    output logic [SA_R-1:0][SA_C-1:0][D_W-1:0]                O_BRAM_WR_MAT,
    input  logic                                              I_BRAM_RD_VLD,
    input  logic [SA_R-1:0][SA_C-1:0][D_W-1:0]                I_BRAM_RD_MAT
);

    localparam int G_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_GAP} state_t;

    state_t                              r_state;
    state_t                              w_state_nxt;
    logic [G_W-1:0]                      r_g;
    logic [G_W-1:0]                      w_g_nxt;
    logic [G_W-1:0]                      w_pick;
    logic                                w_any;

    logic [N_REQ-1:0]                    w_gnt_nxt;
    logic [N_REQ-1:0]                    w_rvld_nxt;
    logic                                w_ena_nxt;
    logic                                w_wea_nxt;
    logic [LINE_W-1:0]                   w_line_nxt;
    logic [COL_W-1:0]                    w_col_nxt;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]  w_wr_mat_nxt;
    logic [SA_R-1:0][SA_C-1:0][D_W-1:0]  w_rd_mat_nxt;

`ifdef MHA_BRAM_ARB_FIXED_PRIO_EN
    // Winner selection: lowest asserted index; scan downwards so the lowest hit is written last.
    always_comb begin
        w_any  = |I_REQ_ENA;
        w_pick = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (I_REQ_ENA[G_W'(i)]) w_pick = G_W'(i);
        end
    end
`else
    logic [G_W-1:0] r_ptr;
    logic [G_W-1:0] w_ptr_nxt;
    int             w_idx;

    // Winner selection: first asserted index at or after r_ptr, wrapping; scan offsets downwards so the nearest hit wins.
    always_comb begin
        w_any  = |I_REQ_ENA;
        w_pick = '0;
        w_idx  = 0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            w_idx = int'(r_ptr) + i;
            if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
            if (I_REQ_ENA[G_W'(w_idx)]) w_pick = G_W'(w_idx);
        end
    end

    // Pointer moves past the owner only when its transaction retires through the gap cycle.
    always_comb begin
        w_ptr_nxt = r_ptr;
        if (r_state == S_GAP) begin
            w_ptr_nxt = (r_g == G_W'(N_REQ - 1)) ? '0 : r_g + 1'b1;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) r_ptr <= '0;
        else          r_ptr <= w_ptr_nxt;
    end
`endif

    // State and owner register; reset abandons any in-flight transaction.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            r_state <= S_IDLE;
            r_g     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_g     <= w_g_nxt;
        end
    end

    // Next-state logic: only S_IDLE looks at non-owner requests.
    always_comb begin
        w_state_nxt = r_state;
        w_g_nxt     = r_g;
        case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_g_nxt     = w_pick;
                    w_state_nxt = I_REQ_WEA[w_pick] ? S_WR : S_RD;
                end
            end
            S_RD: begin
                if (I_BRAM_RD_VLD) w_state_nxt = S_GAP;
            end
            S_WR: begin
                if (!(I_REQ_ENA[r_g] && I_REQ_WEA[r_g])) w_state_nxt = S_GAP;
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output next values: BRAM fields hold their last value unless a new read or beat is launched.
    always_comb begin
        w_gnt_nxt    = O_GNT;
        w_rvld_nxt   = '0;
        w_ena_nxt    = O_BRAM_ENA;
        w_wea_nxt    = O_BRAM_WEA;
        w_line_nxt   = O_BRAM_SEL_LINE;
        w_col_nxt    = O_BRAM_SEL_COL;
        w_wr_mat_nxt = O_BRAM_WR_MAT;
        w_rd_mat_nxt = O_REQ_RD_MAT;
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt = '0;
                w_ena_nxt = 1'b0;
                w_wea_nxt = 1'b0;
                if (w_any) begin
                    w_gnt_nxt = N_REQ'(1) << w_pick;
                    // A write owner's first beat is launched from S_WR, so ENA stays low here.
                    if (!I_REQ_WEA[w_pick]) begin
                        w_ena_nxt  = 1'b1;
                        w_line_nxt = I_REQ_LINE[w_pick];
                        w_col_nxt  = I_REQ_COL[w_pick];
                    end
                end
            end
            S_RD: begin
                // ENA and address are held; the owner dropping ENA does not cancel the read.
                if (I_BRAM_RD_VLD) begin
                    w_rd_mat_nxt = I_BRAM_RD_MAT;
                    w_rvld_nxt   = N_REQ'(1) << r_g;
                    w_ena_nxt    = 1'b0;
                    w_gnt_nxt    = '0;
                end
            end
            S_WR: begin
                if (I_REQ_ENA[r_g] && I_REQ_WEA[r_g]) begin
                    w_ena_nxt    = 1'b1;
                    w_wea_nxt    = 1'b1;
                    w_line_nxt   = I_REQ_LINE[r_g];
                    w_col_nxt    = I_REQ_COL[r_g];
                    w_wr_mat_nxt = I_REQ_WR_MAT[r_g];
                end else begin
                    w_ena_nxt = 1'b0;
                    w_wea_nxt = 1'b0;
                    w_gnt_nxt = '0;
                end
            end
            S_GAP: begin
                w_ena_nxt = 1'b0;
                w_wea_nxt = 1'b0;
                w_gnt_nxt = '0;
            end
            default: begin
                w_ena_nxt = 1'b0;
                w_wea_nxt = 1'b0;
                w_gnt_nxt = '0;
            end
        endcase
    end

    // Output registers: every output leaves the block from a flop.
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
            O_GNT           <= '0;
            O_REQ_RD_VLD    <= '0;
            O_REQ_RD_MAT    <= '0;
            O_BRAM_ENA      <= 1'b0;
            O_BRAM_WEA      <= 1'b0;
            O_BRAM_SEL_LINE <= '0;
            O_BRAM_SEL_COL  <= '0;
            O_BRAM_WR_MAT   <= '0;
        end else begin
            O_GNT           <= w_gnt_nxt;
            O_REQ_RD_VLD    <= w_rvld_nxt;
            O_REQ_RD_MAT    <= w_rd_mat_nxt;
            O_BRAM_ENA      <= w_ena_nxt;
            O_BRAM_WEA      <= w_wea_nxt;
            O_BRAM_SEL_LINE <= w_line_nxt;
            O_BRAM_SEL_COL  <= w_col_nxt;
            O_BRAM_WR_MAT   <= w_wr_mat_nxt;
        end
    end

endmodule

// File: tb/tb_mha_bram_o_arbiter.sv
// Directed bench for mha_bram_o_arbiter: cycle table for reads/round-robin, hand sequences for bursts, stale ENA and reset.
// Inputs change 1 time unit after the rising edge; outputs are checked at that same point (reflecting the edge just taken).
// BRAM read-valid is driven directly by the bench in the cycle it wants the read to complete.
module tb_mha_bram_o_arbiter;

    localparam int N      = 4;
    localparam int D_W    = 16;
    localparam int SA_R   = 16;
    localparam int SA_C   = 16;
    localparam int LINE_W = 6;
    localparam int COL_W  = 3;

    typedef logic [SA_R-1:0][SA_C-1:0][D_W-1:0] mat_t;

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic [N-1:0]                  req_ena = '0;
    logic [N-1:0]                  req_wea = '0;
    logic [N-1:0][LINE_W-1:0]      req_line = '0;
    logic [N-1:0][COL_W-1:0]       req_col = '0;
    logic [N-1:0][SA_R-1:0][SA_C-1:0][D_W-1:0] req_wr_mat = '0;
    logic [N-1:0]                  gnt;
    logic [N-1:0]                  rd_vld;
    mat_t                          rd_mat;
    logic                          bram_ena;
    logic                          bram_wea;
    logic [LINE_W-1:0]             bram_line;
    logic [COL_W-1:0]              bram_col;
    mat_t                          bram_wr_mat;
    logic                          bram_rd_vld = 1'b0;
    mat_t                          bram_rd_mat = '0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mha_bram_o_arbiter #(
        .N_REQ(N), .D_W(D_W), .SA_R(SA_R), .SA_C(SA_C), .LINE_W(LINE_W), .COL_W(COL_W)
    ) dut (
        .I_CLK(clk),
        .I_RST_N(rst_n),
        .I_REQ_ENA(req_ena),
        .I_REQ_WEA(req_wea),
        .I_REQ_LINE(req_line),
        .I_REQ_COL(req_col),
        .I_REQ_WR_MAT(req_wr_mat),
        .O_GNT(gnt),
        .O_REQ_RD_VLD(rd_vld),
        .O_REQ_RD_MAT(rd_mat),
        .O_BRAM_ENA(bram_ena),
        .O_BRAM_WEA(bram_wea),
        .O_BRAM_SEL_LINE(bram_line),
        .O_BRAM_SEL_COL(bram_col),
        .O_BRAM_WR_MAT(bram_wr_mat),
        .I_BRAM_RD_VLD(bram_rd_vld),
        .I_BRAM_RD_MAT(bram_rd_mat)
    );

    typedef struct {
        logic               rst;
        logic [N-1:0]       ena;
        logic               bvld;
        logic               chk_mat;
        logic [N-1:0]       gnt;
        logic [N-1:0]       rvld;
        logic               bena;
        logic               bwea;
        logic [LINE_W-1:0]  bline;
        logic [COL_W-1:0]   bcol;
    } vec_t;

    vec_t vecs[$];

    // Fixed per-requester read addresses.
    logic [LINE_W-1:0] ln [N] = '{6'd8, 6'd5, 6'd12, 6'd20};
    logic [COL_W-1:0]  cl [N] = '{3'd0, 3'd3, 3'd2, 3'd7};

    function automatic mat_t tile(input int seed);
        mat_t m;
        for (int r = 0; r < SA_R; r++)
            for (int c = 0; c < SA_C; c++)
                m[r][c] = D_W'(seed * 257 + r * SA_C + c);
        return m;
    endfunction

    function automatic void add(input logic rst, input logic [N-1:0] ena, input logic bvld,
                                input logic chk_mat, input logic [N-1:0] g, input logic [N-1:0] rv,
                                input logic be, input logic bw, input logic [LINE_W-1:0] bl,
                                input logic [COL_W-1:0] bc);
        vec_t v;
        v.rst = rst; v.ena = ena; v.bvld = bvld; v.chk_mat = chk_mat;
        v.gnt = g; v.rvld = rv; v.bena = be; v.bwea = bw; v.bline = bl; v.bcol = bc;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_mat(input string nm, input mat_t act, input mat_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got [0][0]=%0h [last]=%0h expected [0][0]=%0h [last]=%0h",
                     nm, act[0][0], act[SA_R-1][SA_C-1], exp[0][0], exp[SA_R-1][SA_C-1]);
        end
    endtask

    task automatic chk_o(input string nm, input logic [N-1:0] g, input logic [N-1:0] rv,
                         input logic be, input logic bw);
        chk({nm, "_gnt"}, 32'(gnt), 32'(g));
        chk({nm, "_rvld"}, 32'(rd_vld), 32'(rv));
        chk({nm, "_bena"}, 32'(bram_ena), 32'(be));
        chk({nm, "_bwea"}, 32'(bram_wea), 32'(bw));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int order [5];
`ifdef MHA_BRAM_ARB_FIXED_PRIO_EN
        order = '{0, 0, 0, 0, 0};
`else
        order = '{0, 1, 2, 3, 0};
`endif
        for (int i = 0; i < N; i++) begin
            req_line[i] = ln[i];
            req_col[i]  = cl[i];
        end
        bram_rd_mat = tile(42);

        // Reset state, checked while reset is held.
        #3;
        chk_o("rst", '0, '0, 1'b0, 1'b0);
        chk("rst_line", 32'(bram_line), 32'd0);
        chk("rst_col", 32'(bram_col), 32'd0);
        chk_mat("rst_rdmat", rd_mat, '0);
        chk_mat("rst_wrmat", bram_wr_mat, '0);

        // Single read by requester 1, BRAM answers on the 4th cycle after the grant.
        add(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 6'd0, 3'd0);
        add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 6'd0, 3'd0);
        add(0, 4'b0010, 0, 0, 4'b0010, 4'b0000, 1, 0, 6'd5, 3'd3);
        add(0, 4'b0010, 0, 0, 4'b0010, 4'b0000, 1, 0, 6'd5, 3'd3);
        add(0, 4'b0010, 0, 0, 4'b0010, 4'b0000, 1, 0, 6'd5, 3'd3);
        add(0, 4'b0010, 0, 0, 4'b0010, 4'b0000, 1, 0, 6'd5, 3'd3);
        add(0, 4'b0010, 1, 1, 4'b0000, 4'b0010, 0, 0, 6'd5, 3'd3);
        add(0, 4'b0010, 0, 0, 4'b0000, 4'b0000, 0, 0, 6'd5, 3'd3);
        add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 6'd5, 3'd3);
        // All four requesters read continuously from reset; BRAM answers the cycle after each grant.
        add(1, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, 6'd0, 3'd0);
        for (int k = 0; k < 5; k++) begin
            add(0, 4'b1111, 0, 0, N'(1 << order[k]), 4'b0000, 1, 0, ln[order[k]], cl[order[k]]);
            add(0, 4'b1111, 1, 1, 4'b0000, N'(1 << order[k]), 0, 0, ln[order[k]], cl[order[k]]);
            add(0, 4'b1111, 0, 0, 4'b0000, 4'b0000, 0, 0, ln[order[k]], cl[order[k]]);
        end
        add(0, 4'b0000, 0, 0, 4'b0000, 4'b0000, 0, 0, ln[0], cl[0]);

        foreach (vecs[k]) begin
            rst_n       = !vecs[k].rst;
            req_ena     = vecs[k].ena;
            req_wea     = '0;
            bram_rd_vld = vecs[k].bvld;
            step();
            chk_o($sformatf("v%0d", k), vecs[k].gnt, vecs[k].rvld, vecs[k].bena, vecs[k].bwea);
            chk($sformatf("v%0d_line", k), 32'(bram_line), 32'(vecs[k].bline));
            chk($sformatf("v%0d_col", k), 32'(bram_col), 32'(vecs[k].bcol));
            if (vecs[k].chk_mat) chk_mat($sformatf("v%0d_rdmat", k), rd_mat, tile(42));
        end
        rst_n = 1'b1;
        bram_rd_vld = 1'b0;

        // 8-beat write from requester 0; requester 2 asks for a read during beat 3.
        req_line[0]   = 6'd9;
        req_col[0]    = 3'd0;
        req_wr_mat[0] = tile(100);
        req_wea       = 4'b0001;
        req_ena       = 4'b0001;
        step();
        chk_o("wr_gnt", 4'b0001, '0, 1'b0, 1'b0);
        for (int b = 0; b < 8; b++) begin
            if (b == 3) req_ena[2] = 1'b1;
            step();
            chk_o($sformatf("wr_b%0d", b), 4'b0001, '0, 1'b1, 1'b1);
            chk($sformatf("wr_b%0d_line", b), 32'(bram_line), 32'd9);
            chk($sformatf("wr_b%0d_col", b), 32'(bram_col), 32'(b));
            chk_mat($sformatf("wr_b%0d_dat", b), bram_wr_mat, tile(100 + b));
            if (b < 7) begin
                req_col[0]    = COL_W'(b + 1);
                req_wr_mat[0] = tile(101 + b);
            end else begin
                req_ena[0] = 1'b0;
            end
        end
        step();
        chk_o("wr_end", '0, '0, 1'b0, 1'b0);
        req_wea = '0;
        step();
        chk_o("wr_gap", '0, '0, 1'b0, 1'b0);
        step();
        chk_o("wr_r2gnt", 4'b0100, '0, 1'b1, 1'b0);
        chk("wr_r2line", 32'(bram_line), 32'd12);
        chk("wr_r2col", 32'(bram_col), 32'd2);
        bram_rd_mat = tile(7);
        bram_rd_vld = 1'b1;
        step();
        chk_o("wr_r2vld", '0, 4'b0100, 1'b0, 1'b0);
        chk_mat("wr_r2mat", rd_mat, tile(7));
        bram_rd_vld = 1'b0;
        step();
        chk_o("wr_r2gap", '0, '0, 1'b0, 1'b0);
        req_ena[2]  = 1'b0;
        req_line[0] = ln[0];
        req_col[0]  = cl[0];
        step();
        chk_o("wr_idle", '0, '0, 1'b0, 1'b0);

        // Stale ENA: requester 1 keeps ENA through its read-valid cycle; requester 2 is pending.
        req_ena = 4'b0110;
        step();
        chk_o("st_gnt1", 4'b0010, '0, 1'b1, 1'b0);
        bram_rd_mat = tile(9);
        bram_rd_vld = 1'b1;
        step();
        chk_o("st_vld1", '0, 4'b0010, 1'b0, 1'b0);
        chk_mat("st_mat1", rd_mat, tile(9));
        bram_rd_vld = 1'b0;
        step();
        chk_o("st_gap", '0, '0, 1'b0, 1'b0);
        req_ena[1] = 1'b0;
        step();
        chk_o("st_gnt2", 4'b0100, '0, 1'b1, 1'b0);
        bram_rd_vld = 1'b1;
        step();
        chk_o("st_vld2", '0, 4'b0100, 1'b0, 1'b0);
        bram_rd_vld = 1'b0;
        req_ena = '0;
        step();
        step();
        chk_o("st_idle", '0, '0, 1'b0, 1'b0);

        // Reset during a pending read from requester 3.
        req_ena = 4'b1000;
        step();
        chk_o("rr_gnt3", 4'b1000, '0, 1'b1, 1'b0);
        chk("rr_line3", 32'(bram_line), 32'd20);
        step();
        chk_o("rr_wait3", 4'b1000, '0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_o("rr_async", '0, '0, 1'b0, 1'b0);
        chk("rr_async_line", 32'(bram_line), 32'd0);
        chk("rr_async_col", 32'(bram_col), 32'd0);
        chk_mat("rr_async_rdmat", rd_mat, '0);
        step();
        rst_n       = 1'b1;
        req_ena     = '0;
        bram_rd_vld = 1'b1;
        step();
        chk_o("rr_late_vld", '0, '0, 1'b0, 1'b0);
        bram_rd_vld = 1'b0;
        req_ena = 4'b1001;
        step();
        chk_o("rr_first", 4'b0001, '0, 1'b1, 1'b0);
        chk("rr_first_line", 32'(bram_line), 32'd8);
        bram_rd_vld = 1'b1;
        step();
        chk_o("rr_first_vld", '0, 4'b0001, 1'b0, 1'b0);
        bram_rd_vld = 1'b0;
        req_ena = '0;
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
